// File: rtl/dec_n_seq.sv
// dec_n_seq: registered N-to-2^N one-hot decoder with enable, a valid/ready
// input handshake, and three output modes (LEVEL hold, single-cycle PULSE,
// fixed-length STRETCH with back-pressure).
module dec_n_seq #(
    parameter int N       = 3,
    parameter int STRETCH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        a,
    input  logic [1:0]          mode,
    output logic [(1<<N)-1:0]   d,
    output logic                busy
);

    localparam int OUT_W = 1 << N;
    localparam int CW    = $clog2(STRETCH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD  = 2'd1,
        S_PULSE = 2'd2,
        S_STR   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] d_q, d_d;
    logic             busy_q, busy_d;
    logic             accept;

    // Ready drops only while a stretch is still running (cnt>1); reset and en low also block it.
    assign in_ready = ~rst & en & ~((state_q == S_STR) && (cnt_q > CW'(1)));
    assign accept   = en & in_valid & in_ready;

    // State register: async reset clears the output immediately, no clock needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: en low wins, then a new code, then per-state ageing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            unique case (mode)
                2'b01:   state_d = S_PULSE;
                2'b10:   state_d = S_STR;
                default: state_d = S_HOLD;
            endcase
            cnt_d = CW'(STRETCH);
        end else begin
            unique case (state_q)
                S_PULSE: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
                S_STR: begin
                    if (cnt_q <= CW'(1)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic: load a fresh one-hot code on accept, clear when heading to IDLE, else hold.
    always_comb begin
        d_d    = d_q;
        busy_d = (state_d != S_IDLE);
        if (!en) begin
            d_d = '0;
        end else if (accept) begin
            d_d    = '0;
            d_d[a] = 1'b1;
        end else if (state_d == S_IDLE) begin
            d_d = '0;
        end
    end

    assign d    = d_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_dec_n_seq.sv
// tb_dec_n_seq: directed bench for dec_n_seq (N=3 main instance, plus N=1 and
// N=6 instances exercised in the LEVEL scenario).
module tb_dec_n_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  a;
    logic [1:0]  mode;
    logic [7:0]  d;
    logic        busy;

    logic        in_ready1, busy1;
    logic [0:0]  a1;
    logic [1:0]  d1;
    logic        in_ready6, busy6;
    logic [5:0]  a6;
    logic [63:0] d6;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dec_n_seq #(.N(3), .STRETCH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .mode(mode), .d(d), .busy(busy)
    );

    dec_n_seq #(.N(1), .STRETCH(4)) dut1 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a1), .mode(mode), .d(d1), .busy(busy1)
    );

    dec_n_seq #(.N(6), .STRETCH(4)) dut6 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready6),
        .a(a6), .mode(mode), .d(d6), .busy(busy6)
    );

    // Output must never be multi-hot on any instance.
    always @(negedge clk) begin
        n_cmp = n_cmp + 1;
        if (!$onehot0(d) || !$onehot0(d1) || !$onehot0(d6)) begin
            n_fail = n_fail + 1;
            $display("FAIL onehot0 t=%0t d=%h d1=%b d6=%h required one-hot or zero", $time, d, d1, d6);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; in_valid = 1'b1; a = 3'd5; mode = 2'b00;
        a1 = 1'b0; a6 = 6'd0;
        step(); step();
        n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_d got=%h exp=00", d); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", in_ready); end
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rel_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        n_cmp++; if (d !== 8'h20) begin n_fail++; $display("FAIL first_decode got=%h exp=20", d); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_busy got=%b exp=1", busy); end
    endtask

    task automatic test_level();
        mode = 2'b00; a = 3'd3; a1 = 1'b1; a6 = 6'd45; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (d !== 8'h08) begin n_fail++; $display("FAIL level_hold[%0d] got=%h exp=08", i, d); end
            if (i == 0) begin
                n_cmp++; if (d1 !== 2'b10) begin n_fail++; $display("FAIL level_n1 got=%b exp=10", d1); end
                n_cmp++; if (d6 !== 64'h0000_2000_0000_0000) begin n_fail++; $display("FAIL level_n6 got=%h exp=0000200000000000", d6); end
            end
            if (i < 9) step();
        end
        a = 3'd0; a1 = 1'b0; a6 = 6'd0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_cmp++; if (d !== 8'h01) begin n_fail++; $display("FAIL level_replace got=%h exp=01", d); end
        n_cmp++; if (d1 !== 2'b01) begin n_fail++; $display("FAIL level_n1_replace got=%b exp=01", d1); end
        n_cmp++; if (d6 !== 64'h1) begin n_fail++; $display("FAIL level_n6_replace got=%h exp=1", d6); end
        step();
        n_cmp++; if (d !== 8'h01) begin n_fail++; $display("FAIL level_still got=%h exp=01", d); end
        en = 1'b0;
        step();
        en = 1'b1;
        n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL level_en_clear got=%h exp=00", d); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL level_en_busy got=%b exp=0", busy); end
    endtask

    task automatic test_pulse();
        mode = 2'b01; a = 3'd7; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_cmp++; if (d !== 8'h80) begin n_fail++; $display("FAIL pulse_on got=%h exp=80", d); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pulse_busy got=%b exp=1", busy); end
        step();
        n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL pulse_off got=%h exp=00", d); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pulse_idle got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        mode = 2'b01; a = 3'd1; in_valid = 1'b1;
        step();
        a = 3'd2;
        n_cmp++; if (d !== 8'h02) begin n_fail++; $display("FAIL b2b_first got=%h exp=02", d); end
        step();
        in_valid = 1'b0;
        n_cmp++; if (d !== 8'h04) begin n_fail++; $display("FAIL b2b_second got=%h exp=04", d); end
        step();
        n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL b2b_end got=%h exp=00", d); end
    endtask

    task automatic test_stretch();
        mode = 2'b10; a = 3'd2; in_valid = 1'b1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL str_ready_idle got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            n_cmp++; if (d !== 8'h04) begin n_fail++; $display("FAIL str_hold[%0d] got=%h exp=04", c, d); end
            n_cmp++; if (in_ready !== (c == 4)) begin n_fail++; $display("FAIL str_ready[%0d] got=%b exp=%b", c, in_ready, (c == 4)); end
            if (c < 4) step();
        end
        a = 3'd6; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_cmp++; if (d !== 8'h40) begin n_fail++; $display("FAIL str_seamless got=%h exp=40", d); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL str_seam_ready got=%b exp=0", in_ready); end
        step(); step(); step();
        n_cmp++; if (d !== 8'h40) begin n_fail++; $display("FAIL str_last got=%h exp=40", d); end
        step();
        n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL str_end got=%h exp=00", d); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL str_end_busy got=%b exp=0", busy); end
    endtask

    task automatic test_en_drop();
        mode = 2'b10; a = 3'd4; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        n_cmp++; if (d !== 8'h10) begin n_fail++; $display("FAIL en_pre got=%h exp=10", d); end
        en = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL en_low_ready got=%b exp=0", in_ready); end
        step();
        n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL en_low_d got=%h exp=00", d); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL en_low_busy got=%b exp=0", busy); end
        en = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL en_high_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_async_reset();
        mode = 2'b10; a = 3'd5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        n_cmp++; if (d !== 8'h20) begin n_fail++; $display("FAIL arst_pre got=%h exp=20", d); end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL arst_d got=%h exp=00", d); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got=%b exp=0", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_ready got=%b exp=0", in_ready); end
        step();
        rst = 1'b0;
        mode = 2'b00; a = 3'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_cmp++; if (d !== 8'h08) begin n_fail++; $display("FAIL arst_resume got=%h exp=08", d); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL arst_resume_busy got=%b exp=1", busy); end
    endtask

    initial begin
        test_reset();
        test_level();
        test_pulse();
        test_back_to_back();
        test_stretch();
        test_en_drop();
        test_async_reset();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
